// File: rtl/line_align_pkg.sv
// Shared defaults and the pixel type for the line alignment core.
// Helper cnt_width() sizes counters so that they never collapse to zero bits.
package line_align_pkg;

  localparam int DEF_DATA_WIDTH   = 14;
  localparam int DEF_BUFFER_DEPTH = 256;
  localparam int DEF_FIFO_WIDTH   = 8;
  localparam int DEF_LINE_NUM     = 3;
  localparam int DEF_IMAGE_WIDTH  = 240;

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_fifo.sv
// One line buffer: synchronous FIFO with wrapping pointers over an inferred RAM.
// The read port is asynchronous, so a pop returns the oldest entry on the same edge that accepts the beat.
module line_fifo
  import line_align_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
  parameter int FIFO_WIDTH   = DEF_FIFO_WIDTH
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [FIFO_WIDTH-1:0] wr_ptr;
  logic [FIFO_WIDTH-1:0] rd_ptr;

  // Contents carry no reset; stale entries are overwritten before they are read again.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + FIFO_WIDTH'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + FIFO_WIDTH'(1);
      end
    end
  end

  // With a full buffer the read sees the old entry before this edge's write lands.
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/line_align_core.sv
// Vertical line aligner: presents LINE_NUM pixels of the same column from consecutive raster lines.
// Define LINE_ALIGN_ZERO_OUT_EN to force data_out to zero whenever dataout_valid is low.
module line_align_core
  import line_align_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
  parameter int FIFO_WIDTH   = DEF_FIFO_WIDTH,
  parameter int LINE_NUM     = DEF_LINE_NUM,
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           datain_valid,
  output logic [LINE_NUM*DATA_WIDTH-1:0] data_out,
  output logic                           dataout_valid
);

  localparam int COL_W  = cnt_width(IMAGE_WIDTH);
  localparam int LCNT_W = cnt_width(LINE_NUM);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [LCNT_W-1:0] LINE_FULL = LCNT_W'(LINE_NUM - 1);

  logic [COL_W-1:0]               col_cnt;
  logic [LCNT_W-1:0]              line_cnt;
  logic                           lines_ready;
  logic                           out_fire;
  logic [DATA_WIDTH-1:0]          tap [LINE_NUM];
  logic [LINE_NUM*DATA_WIDTH-1:0] taps_flat;

  assign lines_ready = (line_cnt == LINE_FULL);
  assign out_fire    = datain_valid && lines_ready;

  // Column wraps each line; the filled-line count saturates once every buffer holds a full line.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      col_cnt  <= '0;
      line_cnt <= '0;
    end else if (datain_valid) begin
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        if (!lines_ready) begin
          line_cnt <= line_cnt + LCNT_W'(1);
        end
      end else begin
        col_cnt <= col_cnt + COL_W'(1);
      end
    end
  end

  assign tap[0] = data_in;

  // Stage k fills once k-1 lines are buffered upstream and starts draining after k full lines,
  // so each buffer settles at exactly IMAGE_WIDTH entries.
  for (genvar k = 1; k < LINE_NUM; k++) begin : g_stage
    logic push;
    logic pop;

    assign push = datain_valid && (int'(line_cnt) >= k - 1);
    assign pop  = datain_valid && (int'(line_cnt) >= k);

    line_fifo #(
      .DATA_WIDTH   (DATA_WIDTH),
      .BUFFER_DEPTH (BUFFER_DEPTH),
      .FIFO_WIDTH   (FIFO_WIDTH)
    ) u_fifo (
      .clk     (clk),
      .arstn   (arstn),
      .wr_en   (push),
      .wr_data (tap[k-1]),
      .rd_en   (pop),
      .rd_data (tap[k])
    );
  end

  always_comb begin
    taps_flat = '0;
    for (int k = 0; k < LINE_NUM; k++) begin
      taps_flat[k*DATA_WIDTH +: DATA_WIDTH] = tap[k];
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      data_out      <= '0;
      dataout_valid <= 1'b0;
    end else begin
      dataout_valid <= out_fire;
`ifdef LINE_ALIGN_ZERO_OUT_EN
      data_out <= out_fire ? taps_flat : '0;
`else
      if (out_fire) begin
        data_out <= taps_flat;
      end
`endif
    end
  end

endmodule

// File: tb/tb_line_align_core.sv
// Self-checking bench for line_align_core: default build plus a LINE_NUM=2, full-buffer instance.
module tb_line_align_core;

  localparam int DW = 14;
  localparam int W  = 240;
  localparam int L  = 3;
  localparam int W2 = 256;

  typedef struct {
    int lines;
    int gap_pct;
    bit distinct;
    int exp_valid;
  } scen_t;

  logic            clk = 1'b0;
  logic            arstn = 1'b0;
  logic [DW-1:0]   data_in = '0;
  logic            datain_valid = 1'b0;
  logic [L*DW-1:0] data_out;
  logic            dataout_valid;
  logic [DW-1:0]   data_in2 = '0;
  logic            datain_valid2 = 1'b0;
  logic [2*DW-1:0] data_out2;
  logic            dataout_valid2;

  always #5 clk = ~clk;

  line_align_core dut (
    .clk           (clk),
    .arstn         (arstn),
    .data_in       (data_in),
    .datain_valid  (datain_valid),
    .data_out      (data_out),
    .dataout_valid (dataout_valid)
  );

  line_align_core #(.LINE_NUM(2), .IMAGE_WIDTH(W2)) dut2 (
    .clk           (clk),
    .arstn         (arstn),
    .data_in       (data_in2),
    .datain_valid  (datain_valid2),
    .data_out      (data_out2),
    .dataout_valid (dataout_valid2)
  );

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int valid2_seen = 0;
  logic [DW-1:0]   hist[$];
  logic [L*DW-1:0] exp_q[$];
  logic [L*DW-1:0] last_out = '0;
  logic [DW-1:0]   hist2[$];
  logic [2*DW-1:0] last_out2 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // One clock on the default instance; the history queue is the reference model.
  task automatic cycle1(input bit v, input logic [DW-1:0] d);
    bit exp_v = 1'b0;
    int n;
    logic [L*DW-1:0] e;
    datain_valid = v;
    data_in = d;
    if (v) begin
      hist.push_back(d);
      n = hist.size() - 1;
      if (n >= (L-1)*W) begin
        exp_q.push_back({hist[n-2*W], hist[n-W], d});
        exp_v = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    datain_valid = 1'b0;
    chk("valid", dataout_valid, exp_v);
    if (dataout_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("data", data_out, e);
        last_out = e;
        valid_seen++;
      end
    end else begin
`ifdef LINE_ALIGN_ZERO_OUT_EN
      chk("zero_when_invalid", data_out, '0);
`else
      chk("hold_when_invalid", data_out, last_out);
`endif
    end
  endtask

  task automatic cycle2(input bit v, input logic [DW-1:0] d);
    bit exp_v = 1'b0;
    int n;
    logic [2*DW-1:0] e = '0;
    datain_valid2 = v;
    data_in2 = d;
    if (v) begin
      hist2.push_back(d);
      n = hist2.size() - 1;
      if (n >= W2) begin
        e = {hist2[n-W2], d};
        exp_v = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    datain_valid2 = 1'b0;
    chk("valid2", dataout_valid2, exp_v);
    if (exp_v) begin
      chk("slice1_delay256", data_out2, e);
      last_out2 = e;
      valid2_seen++;
    end else begin
`ifdef LINE_ALIGN_ZERO_OUT_EN
      chk("zero_when_invalid2", data_out2, '0);
`else
      chk("hold_when_invalid2", data_out2, last_out2);
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    arstn = 1'b0;
    #1;
    chk("rst_valid", dataout_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_valid2", dataout_valid2, 0);
    chk("rst_data2", data_out2, 0);
    hist.delete();
    exp_q.delete();
    hist2.delete();
    last_out = '0;
    last_out2 = '0;
    @(negedge clk);
    arstn = 1'b1;
  endtask

  function automatic logic [DW-1:0] pix(input bit distinct, input int ln, input int j);
    return distinct ? DW'((ln + 1) * 256 + j) : DW'(j + 1);
  endfunction

  task automatic run_scen(input scen_t s);
    valid_seen = 0;
    for (int ln = 0; ln < s.lines; ln++) begin
      for (int j = 0; j < W; j++) begin
        int g = 0;
        while (g < 8 && int'($urandom_range(99)) < s.gap_pct) begin
          cycle1(1'b0, DW'($urandom));
          g++;
        end
        cycle1(1'b1, pix(s.distinct, ln, j));
      end
    end
    repeat (3) cycle1(1'b0, DW'($urandom));
    chk("valid_count", valid_seen, s.exp_valid);
  endtask

  initial begin
    scen_t tbl[5];
    tbl[0] = '{12, 0,  1'b0, 2400};
    tbl[1] = '{12, 0,  1'b1, 2400};
    tbl[2] = '{6,  50, 1'b1, 960};
    tbl[3] = '{3,  30, 1'b0, 240};
    tbl[4] = '{2,  0,  1'b1, 0};

    #2;
    chk("init_valid", dataout_valid, 0);
    chk("init_data", data_out, 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_scen(tbl[i]);
    end

    // Reset in the middle of line 5, then the fill must restart from scratch.
    do_reset();
    for (int ln = 0; ln < 4; ln++)
      for (int j = 0; j < W; j++) cycle1(1'b1, pix(1'b1, ln, j));
    for (int j = 0; j < 100; j++) cycle1(1'b1, pix(1'b1, 4, j));
    do_reset();
    valid_seen = 0;
    for (int ln = 0; ln < 3; ln++)
      for (int j = 0; j < W; j++) cycle1(1'b1, pix(1'b1, ln + 10, j));
    cycle1(1'b0, DW'($urandom));
    chk("post_reset_valid_count", valid_seen, 240);

    // Two-line instance with the buffer completely full, random gaps.
    do_reset();
    valid2_seen = 0;
    for (int i = 0; i < 3*W2; i++) begin
      if ($urandom_range(3) == 0) cycle2(1'b0, DW'($urandom));
      cycle2(1'b1, DW'($urandom));
    end
    cycle2(1'b0, DW'($urandom));
    chk("dut2_valid_count", valid2_seen, 2*W2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
